// File: rtl/hazard_ctl_pkg.sv
// ---------------------------------------------------------------------------
// hazard_ctl_pkg
// Shared encodings for the pipeline sequencing controller:
//   - EX-stage forwarding select values (FWD_*)
//   - PC-source select values (PC_SEL_*)
//   - result-source code that marks a load in E
//   - trap FSM state type
//   - reg_match helper: a live (non-x0) destination equals a source
// ---------------------------------------------------------------------------
package hazard_ctl_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_WB  = 2'b01;  // operand from W-stage result
  localparam logic [1:0] FWD_MEM = 2'b10;  // operand from M-stage ALU result

  localparam logic [1:0] PC_SEL_PLUS4  = 2'b00;
  localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
  localparam logic [1:0] PC_SEL_MTVEC  = 2'b10;
  localparam logic [1:0] PC_SEL_MEPC   = 2'b11;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } trap_state_t;

  // x0 is hard-wired to zero, so it never creates a dependency.
  function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
    return (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// ---------------------------------------------------------------------------
// hazard_fwd_unit
// Combinational forwarding comparator for one EX-stage source operand.
// Ports:
//   rs_e       in  5  source register of the instruction in E
//   rd_m       in  5  destination register in M
//   reg_wr_m   in  1  M writes the register file
//   rd_w       in  5  destination register in W
//   reg_wr_w   in  1  W writes the register file
//   fwd_sel    out 2  FWD_MEM / FWD_WB / FWD_RF
// The younger producer (M) wins over the older one (W).
// ---------------------------------------------------------------------------
module hazard_fwd_unit
  import hazard_ctl_pkg::*;
(
  input  logic [4:0] rs_e,
  input  logic [4:0] rd_m,
  input  logic       reg_wr_m,
  input  logic [4:0] rd_w,
  input  logic       reg_wr_w,
  output logic [1:0] fwd_sel
);

  always_comb begin
    fwd_sel = FWD_RF;
    if (reg_wr_m && reg_match(rd_m, rs_e)) begin
      fwd_sel = FWD_MEM;
    end else if (reg_wr_w && reg_match(rd_w, rs_e)) begin
      fwd_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctl.sv
// ---------------------------------------------------------------------------
// hazard_ctl
// Pipeline sequencing controller for the 5-stage core: forwarding selects,
// stage clock enables, flushes, PC-source select and the trap FSM.
// Ports:
//   i_clk, i_rst_n                   clock, synchronous active-low reset
//   i_rs1_d, i_rs2_d                 D-stage sources
//   i_rs1_e, i_rs2_e, i_rd_e         E-stage sources / destination
//   i_reg_wr_e, i_result_src_e       E writes regfile / result source
//   i_rd_m, i_reg_wr_m               M destination / write enable
//   i_rd_w, i_reg_wr_w               W destination / write enable
//   i_pc_src_e                       taken branch/jump resolved in E
//   i_ecall_m, i_mret_m              trap entry / return present in M
//   i_dmem_busy                      data memory not ready
//   o_fwd_a_e, o_fwd_b_e             EX operand forwarding selects
//   o_pc_sel                         next-PC source
//   o_*_clk_en                       pipeline register enables
//   o_if_id_flush, o_id_ex_flush     control / bubble flushes
//   o_id_ex_flush_exception_m        trap flush of ID/EX
//   o_ex_mem_flush                   trap flush of EX/MEM
//   o_trap_active                    FSM in TRAP
//   o_mem_timeout                    sticky data-memory watchdog
// Priority: reset > trap > memory wait > control flush > load-use stall.
// ---------------------------------------------------------------------------
module hazard_ctl
  import hazard_ctl_pkg::*;
#(
  parameter int TRAP_CYCLES = 1,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [4:0] i_rs1_d,
  input  logic [4:0] i_rs2_d,
  input  logic [4:0] i_rs1_e,
  input  logic [4:0] i_rs2_e,
  input  logic [4:0] i_rd_e,
  input  logic       i_reg_wr_e,
  input  logic [1:0] i_result_src_e,
  input  logic [4:0] i_rd_m,
  input  logic [4:0] i_rd_w,
  input  logic       i_reg_wr_m,
  input  logic       i_reg_wr_w,
  input  logic       i_pc_src_e,
  input  logic       i_ecall_m,
  input  logic       i_mret_m,
  input  logic       i_dmem_busy,
  output logic [1:0] o_fwd_a_e,
  output logic [1:0] o_fwd_b_e,
  output logic [1:0] o_pc_sel,
  output logic       o_if_clk_en,
  output logic       o_if_id_clk_en,
  output logic       o_id_ex_clk_en,
  output logic       o_ex_mem_clk_en,
  output logic       o_mem_wb_clk_en,
  output logic       o_if_id_flush,
  output logic       o_id_ex_flush,
  output logic       o_id_ex_flush_exception_m,
  output logic       o_ex_mem_flush,
  output logic       o_trap_active,
  output logic       o_mem_timeout
);

  localparam logic [3:0] TRAP_LOAD = 4'(TRAP_CYCLES);
  localparam logic [7:0] BUSY_MAX  = 8'(MEM_TIMEOUT);

  // -------------------------------------------------------------------------
  // Forwarding: one comparator per EX operand
  // -------------------------------------------------------------------------
  logic [4:0] rs_e    [2];
  logic [1:0] fwd_sel [2];

  assign rs_e[0] = i_rs1_e;
  assign rs_e[1] = i_rs2_e;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      hazard_fwd_unit u_fwd (
        .rs_e     (rs_e[gi]),
        .rd_m     (i_rd_m),
        .reg_wr_m (i_reg_wr_m),
        .rd_w     (i_rd_w),
        .reg_wr_w (i_reg_wr_w),
        .fwd_sel  (fwd_sel[gi])
      );
    end
  endgenerate

  assign o_fwd_a_e = fwd_sel[0];
  assign o_fwd_b_e = fwd_sel[1];

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  trap_state_t state_reg, state_next;
  logic [3:0]  trap_cnt_reg, trap_cnt_next;
  logic [7:0]  busy_cnt_reg, busy_cnt_next;
  logic        timeout_reg, timeout_next;

  logic load_use;

  assign load_use = (i_result_src_e == RESULT_SRC_LOAD) && i_reg_wr_e &&
                    (reg_match(i_rd_e, i_rs1_d) || reg_match(i_rd_e, i_rs2_d));

  // Watchdog counts consecutive busy cycles in any FSM state.
  always_comb begin
    busy_cnt_next = 8'd0;
    if (i_dmem_busy) begin
      busy_cnt_next = (busy_cnt_reg >= BUSY_MAX) ? BUSY_MAX : busy_cnt_reg + 8'd1;
    end
    timeout_next = timeout_reg || (busy_cnt_next == BUSY_MAX);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg    <= ST_RUN;
      trap_cnt_reg <= 4'd0;
      busy_cnt_reg <= 8'd0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      trap_cnt_reg <= trap_cnt_next;
      busy_cnt_reg <= busy_cnt_next;
      timeout_reg  <= timeout_next;
    end
  end

  assign o_mem_timeout = timeout_reg;

  // -------------------------------------------------------------------------
  // Next state and sequencing outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_next                = state_reg;
    trap_cnt_next             = trap_cnt_reg;
    o_pc_sel                  = PC_SEL_PLUS4;
    o_if_clk_en               = 1'b1;
    o_if_id_clk_en            = 1'b1;
    o_id_ex_clk_en            = 1'b1;
    o_ex_mem_clk_en           = 1'b1;
    o_mem_wb_clk_en           = 1'b1;
    o_if_id_flush             = 1'b0;
    o_id_ex_flush             = 1'b0;
    o_id_ex_flush_exception_m = 1'b0;
    o_ex_mem_flush            = 1'b0;
    o_trap_active             = 1'b0;

    // While reset is asserted the outputs hold their idle values.
    if (i_rst_n) begin
      case (state_reg)
        ST_TRAP: begin
          // Drain: keep flushing, ignore new ecall/mret.
          o_trap_active             = 1'b1;
          o_if_id_flush             = 1'b1;
          o_id_ex_flush_exception_m = 1'b1;
          o_ex_mem_flush            = 1'b1;
          if (trap_cnt_reg <= 4'd1) begin
            state_next    = ST_RUN;
            trap_cnt_next = 4'd0;
          end else begin
            trap_cnt_next = trap_cnt_reg - 4'd1;
          end
        end
        default: begin
          if (i_ecall_m || i_mret_m) begin
            o_pc_sel                  = i_ecall_m ? PC_SEL_MTVEC : PC_SEL_MEPC;
            o_if_id_flush             = 1'b1;
            o_id_ex_flush_exception_m = 1'b1;
            o_ex_mem_flush            = 1'b1;
            state_next                = ST_TRAP;
            trap_cnt_next             = TRAP_LOAD;
          end else if (i_dmem_busy) begin
            // Freeze the whole pipe; pending branch/stall re-resolve later.
            o_if_clk_en     = 1'b0;
            o_if_id_clk_en  = 1'b0;
            o_id_ex_clk_en  = 1'b0;
            o_ex_mem_clk_en = 1'b0;
            o_mem_wb_clk_en = 1'b0;
          end else if (i_pc_src_e) begin
            o_pc_sel      = PC_SEL_BRANCH;
            o_if_id_flush = 1'b1;
            o_id_ex_flush = 1'b1;
          end else if (load_use) begin
            // Hold IF and D, inject a bubble into E.
            o_if_clk_en    = 1'b0;
            o_if_id_clk_en = 1'b0;
            o_id_ex_flush  = 1'b1;
          end
        end
      endcase
    end
  end

endmodule
